// File: rtl/ext_bus_pkg.sv
// Shared types and width helpers for the external bus router.
package ext_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2,
    ERROR  = 2'd3
  } bus_state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_UNMAPPED = 2'd1,
    ERR_CONFLICT = 2'd2,
    ERR_TIMEOUT  = 2'd3
  } err_cause_t;

  localparam int ERR_CAUSE_W = 2;

  // Width of a channel index; never narrower than one bit.
  function automatic int ch_idx_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  // Width of the access timeout counter; TIMEOUT = 0 still needs one bit.
  function automatic int tmo_cnt_w(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/ext_bus_timeout.sv
// Access timeout counter: cleared on ACCESS entry, counts wait cycles,
// flags expiry on the cycle whose increment reaches TIMEOUT.
module ext_bus_timeout #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_inc_s;

  // Next count and expiry compare; a zero TIMEOUT never expires.
  always_comb begin
    cnt_inc_s = cnt_q + CNT_W'(1);
    cnt_d     = cnt_q;
    expired_o = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_inc_s;
    end else begin
      cnt_d = cnt_q;
    end
    if ((TIMEOUT != 0) && en_i && (cnt_inc_s == CNT_W'(TIMEOUT))) begin
      expired_o = 1'b1;
    end else begin
      expired_o = 1'b0;
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ext_bus_router.sv
// CPU-to-channel bus router: decodes the top address bits into a channel,
// runs one access at a time through IDLE/ACCESS/DONE/ERROR and keeps a
// sticky record of the first failing access.
module ext_bus_router
  import ext_bus_pkg::*;
#(
  parameter int ADDR_W  = 24,
  parameter int DATA_W  = 16,
  parameter int SEL_W   = 3,
  parameter int NUM_CH  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [ADDR_W-1:0]          addr_i,
  input  logic                       re_i,
  input  logic                       we_i,
  input  logic [DATA_W-1:0]          wdata_i,
  output logic [DATA_W-1:0]          rdata_o,
  output logic                       needWait_o,
  output logic [ADDR_W-SEL_W-1:0]    ch_addr_o,
  output logic [DATA_W-1:0]          ch_wdata_o,
  output logic [NUM_CH-1:0]          ch_re_o,
  output logic [NUM_CH-1:0]          ch_we_o,
  input  logic [NUM_CH*DATA_W-1:0]   ch_rdata_i,
  input  logic [NUM_CH-1:0]          ch_needWait_i,
  input  logic                       clr_err_i,
  output logic                       err_o,
  output logic [ADDR_W-1:0]          err_addr_o,
  output logic [ERR_CAUSE_W-1:0]     err_cause_o
);

  localparam int OFF_W = ADDR_W - SEL_W;
  localparam int IDX_W = ch_idx_w(NUM_CH);
  localparam int CNT_W = tmo_cnt_w(TIMEOUT);

  bus_state_t          state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rd_q, rd_d;
  logic [IDX_W-1:0]    ch_q, ch_d;
  logic [NUM_CH-1:0]   ch_re_q, ch_re_d;
  logic [NUM_CH-1:0]   ch_we_q, ch_we_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   err_addr_q, err_addr_d;
  err_cause_t          err_cause_q, err_cause_d;

  logic [SEL_W-1:0]    req_idx_s;
  logic [IDX_W-1:0]    req_ch_s;
  logic [NUM_CH-1:0]   req_oh_s;
  logic                req_unmapped_s;
  logic                sel_wait_s;
  logic [DATA_W-1:0]   sel_rdata_s;
  logic                tmo_clr_s, tmo_en_s, tmo_exp_s;
  logic                err_evt_s;
  err_cause_t          err_evt_cause_s;
  logic [ADDR_W-1:0]   err_evt_addr_s;
  logic                need_wait_s;

  ext_bus_timeout #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timeout (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (tmo_clr_s),
    .en_i      (tmo_en_s),
    .expired_o (tmo_exp_s)
  );

  // Decode the incoming request address into a region index and one-hot strobe.
  always_comb begin
    req_idx_s      = addr_i[ADDR_W-1 -: SEL_W];
    req_ch_s       = req_idx_s[IDX_W-1:0];
    req_unmapped_s = (32'(req_idx_s) >= 32'(NUM_CH));
    req_oh_s       = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      req_oh_s[k] = (req_ch_s == IDX_W'(k));
    end
  end

  // Select wait and read data of the latched channel.
  always_comb begin
    sel_wait_s  = ch_needWait_i[ch_q];
    sel_rdata_s = ch_rdata_i[32'(ch_q)*DATA_W +: DATA_W];
  end

  // Access sequencer: next state, latches, strobes and error events.
  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    rd_d            = rd_q;
    ch_d            = ch_q;
    rdata_d         = rdata_q;
    ch_re_d         = '0;
    ch_we_d         = '0;
    tmo_clr_s       = 1'b0;
    tmo_en_s        = 1'b0;
    err_evt_s       = 1'b0;
    err_evt_cause_s = ERR_NONE;
    err_evt_addr_s  = addr_q;
    need_wait_s     = 1'b0;
    case (state_q)
      IDLE: begin
        need_wait_s = re_i | we_i;
        if (re_i || we_i) begin
          addr_d  = addr_i;
          wdata_d = wdata_i;
          rd_d    = re_i;
          ch_d    = req_ch_s;
          if (re_i && we_i) begin
            state_d         = ERROR;
            err_evt_s       = 1'b1;
            err_evt_cause_s = ERR_CONFLICT;
            err_evt_addr_s  = addr_i;
            rdata_d         = '1;
          end else if (req_unmapped_s) begin
            state_d         = ERROR;
            err_evt_s       = 1'b1;
            err_evt_cause_s = ERR_UNMAPPED;
            err_evt_addr_s  = addr_i;
            if (re_i) begin
              rdata_d = '1;
            end else begin
              rdata_d = rdata_q;
            end
          end else begin
            state_d   = ACCESS;
            tmo_clr_s = 1'b1;
            if (re_i) begin
              ch_re_d = req_oh_s;
            end else begin
              ch_we_d = req_oh_s;
            end
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        need_wait_s = 1'b1;
        if (!sel_wait_s) begin
          state_d = DONE;
          if (rd_q) begin
            rdata_d = sel_rdata_s;
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          tmo_en_s = 1'b1;
          if (tmo_exp_s) begin
            state_d         = ERROR;
            err_evt_s       = 1'b1;
            err_evt_cause_s = ERR_TIMEOUT;
            err_evt_addr_s  = addr_q;
            if (rd_q) begin
              rdata_d = '1;
            end else begin
              rdata_d = rdata_q;
            end
          end else begin
            ch_re_d = ch_re_q;
            ch_we_d = ch_we_q;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      ERROR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sticky error record: first error wins unless cleared in the same cycle.
  always_comb begin
    err_d       = err_q;
    err_addr_d  = err_addr_q;
    err_cause_d = err_cause_q;
    if (err_evt_s) begin
      err_d = 1'b1;
      if (!err_q || clr_err_i) begin
        err_addr_d  = err_evt_addr_s;
        err_cause_d = err_evt_cause_s;
      end else begin
        err_addr_d  = err_addr_q;
        err_cause_d = err_cause_q;
      end
    end else if (clr_err_i) begin
      err_d       = 1'b0;
      err_addr_d  = '0;
      err_cause_d = ERR_NONE;
    end else begin
      err_d = err_q;
    end
  end

  // State, latch and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      rd_q        <= 1'b0;
      ch_q        <= '0;
      ch_re_q     <= '0;
      ch_we_q     <= '0;
      err_q       <= 1'b0;
      err_addr_q  <= '0;
      err_cause_q <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      rd_q        <= rd_d;
      ch_q        <= ch_d;
      ch_re_q     <= ch_re_d;
      ch_we_q     <= ch_we_d;
      err_q       <= err_d;
      err_addr_q  <= err_addr_d;
      err_cause_q <= err_cause_d;
    end
  end

  assign rdata_o     = rdata_q;
  assign needWait_o  = need_wait_s;
  assign ch_addr_o   = addr_q[OFF_W-1:0];
  assign ch_wdata_o  = wdata_q;
  assign ch_re_o     = ch_re_q;
  assign ch_we_o     = ch_we_q;
  assign err_o       = err_q;
  assign err_addr_o  = err_addr_q;
  assign err_cause_o = err_cause_q;

endmodule

// File: tb/tb_ext_bus_router.sv
// Directed bench for ext_bus_router with TIMEOUT = 8.
module tb_ext_bus_router;

  logic        clk;
  logic        rst_n;
  logic [23:0] addr;
  logic        re;
  logic        we;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        need_wait;
  logic [20:0] ch_addr;
  logic [15:0] ch_wdata;
  logic [3:0]  ch_re;
  logic [3:0]  ch_we;
  logic [63:0] ch_rdata;
  logic [3:0]  ch_wait;
  logic        clr_err;
  logic        err;
  logic [23:0] err_addr;
  logic [1:0]  err_cause;

  int n_vec = 0;
  int n_err = 0;

  ext_bus_router #(
    .ADDR_W (24), .DATA_W (16), .SEL_W (3), .NUM_CH (4), .TIMEOUT (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .addr_i        (addr),
    .re_i          (re),
    .we_i          (we),
    .wdata_i       (wdata),
    .rdata_o       (rdata),
    .needWait_o    (need_wait),
    .ch_addr_o     (ch_addr),
    .ch_wdata_o    (ch_wdata),
    .ch_re_o       (ch_re),
    .ch_we_o       (ch_we),
    .ch_rdata_i    (ch_rdata),
    .ch_needWait_i (ch_wait),
    .clr_err_i     (clr_err),
    .err_o         (err),
    .err_addr_o    (err_addr),
    .err_cause_o   (err_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  initial begin
    rst_n = 1'b0; re = 1'b0; we = 1'b0; addr = 24'h0; wdata = 16'h0;
    clr_err = 1'b0; ch_wait = 4'b0000;
    ch_rdata = {16'h5A5A, 16'hBEEF, 16'h1111, 16'h2222};
    tick(); tick();
    chk("rst_rdata",     32'(rdata),     32'h0);
    chk("rst_ch_re",     32'(ch_re),     32'h0);
    chk("rst_ch_we",     32'(ch_we),     32'h0);
    chk("rst_ch_addr",   32'(ch_addr),   32'h0);
    chk("rst_ch_wdata",  32'(ch_wdata),  32'h0);
    chk("rst_err",       32'(err),       32'h0);
    chk("rst_err_addr",  32'(err_addr),  32'h0);
    chk("rst_err_cause", 32'(err_cause), 32'h0);
    chk("rst_needwait",  32'(need_wait), 32'h0);
    rst_n = 1'b1;
    tick();

    // Zero-wait read of channel 2 (region 2 starts at 0x400000).
    addr = 24'h400010; re = 1'b1; #1;
    chk("rd_idle_wait", 32'(need_wait), 32'h1);
    tick();
    chk("rd_acc_re",    32'(ch_re),     32'h4);
    chk("rd_acc_addr",  32'(ch_addr),   32'h000010);
    chk("rd_acc_wait",  32'(need_wait), 32'h1);
    tick();
    chk("rd_done_wait", 32'(need_wait), 32'h0);
    chk("rd_done_re",   32'(ch_re),     32'h0);
    chk("rd_done_data", 32'(rdata),     32'hBEEF);
    re = 1'b0;
    tick();
    chk("rd_idle_after", 32'(need_wait), 32'h0);

    // Write to channel 0 with three wait cycles.
    addr = 24'h000004; wdata = 16'h1234; we = 1'b1; ch_wait = 4'b0001; #1;
    chk("wr_idle_wait", 32'(need_wait), 32'h1);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) begin
        ch_wait = 4'b0000; #1;
      end
      chk("wr_acc_we",    32'(ch_we),     32'h1);
      chk("wr_acc_wait",  32'(need_wait), 32'h1);
    end
    chk("wr_wdata", 32'(ch_wdata), 32'h1234);
    tick();
    chk("wr_done_wait",  32'(need_wait), 32'h0);
    chk("wr_done_we",    32'(ch_we),     32'h0);
    chk("wr_done_err",   32'(err),       32'h0);
    chk("wr_rdata_hold", 32'(rdata),     32'hBEEF);
    we = 1'b0;
    tick();

    // Unmapped read (index 7).
    addr = 24'hE00000; re = 1'b1;
    tick();
    chk("um_wait",  32'(need_wait), 32'h0);
    chk("um_re",    32'(ch_re),     32'h0);
    chk("um_rdata", 32'(rdata),     32'hFFFF);
    chk("um_err",   32'(err),       32'h1);
    chk("um_cause", 32'(err_cause), 32'h1);
    chk("um_addr",  32'(err_addr),  32'hE00000);
    re = 1'b0;
    tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("clr1_err",   32'(err),       32'h0);
    chk("clr1_cause", 32'(err_cause), 32'h0);
    chk("clr1_addr",  32'(err_addr),  32'h0);

    // Timeout on channel 1 with wait stuck high.
    addr = 24'h200000; re = 1'b1; ch_wait = 4'b0010;
    tick();
    for (int i = 1; i <= 8; i++) begin
      chk("to_acc_re",   32'(ch_re),     32'h2);
      chk("to_acc_wait", 32'(need_wait), 32'h1);
      tick();
    end
    chk("to_err_re",    32'(ch_re),     32'h0);
    chk("to_err_wait",  32'(need_wait), 32'h0);
    chk("to_err",       32'(err),       32'h1);
    chk("to_cause",     32'(err_cause), 32'h3);
    chk("to_addr",      32'(err_addr),  32'h200000);
    chk("to_rdata",     32'(rdata),     32'hFFFF);
    re = 1'b0; ch_wait = 4'b0000;
    tick();

    // A second error keeps the first record.
    addr = 24'hE00000; re = 1'b1;
    tick();
    chk("err2_cause", 32'(err_cause), 32'h3);
    chk("err2_addr",  32'(err_addr),  32'h200000);
    re = 1'b0;
    tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("clr2_err", 32'(err), 32'h0);

    // Read and write together on a mapped region.
    addr = 24'h600000; re = 1'b1; we = 1'b1;
    tick();
    chk("cf_re",    32'(ch_re),     32'h0);
    chk("cf_we",    32'(ch_we),     32'h0);
    chk("cf_err",   32'(err),       32'h1);
    chk("cf_cause", 32'(err_cause), 32'h2);
    chk("cf_addr",  32'(err_addr),  32'h600000);
    re = 1'b0; we = 1'b0;
    tick();

    // Clear coinciding with a new error: the new error is recorded.
    addr = 24'hA00000; re = 1'b1; clr_err = 1'b1;
    tick();
    clr_err = 1'b0; re = 1'b0;
    chk("cc_err",   32'(err),       32'h1);
    chk("cc_cause", 32'(err_cause), 32'h1);
    chk("cc_addr",  32'(err_addr),  32'hA00000);
    tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("clr3_err", 32'(err), 32'h0);

    // Reset in the middle of an access to channel 3.
    addr = 24'h600020; re = 1'b1; ch_wait = 4'b1000;
    tick();
    chk("rs_acc_re", 32'(ch_re), 32'h8);
    rst_n = 1'b0; re = 1'b0;
    tick();
    chk("rs_re",    32'(ch_re),     32'h0);
    chk("rs_wait",  32'(need_wait), 32'h0);
    chk("rs_rdata", 32'(rdata),     32'h0);
    chk("rs_addr",  32'(ch_addr),   32'h0);
    rst_n = 1'b1; ch_wait = 4'b0000; re = 1'b1;
    tick();
    chk("rs2_acc_re",   32'(ch_re),   32'h8);
    chk("rs2_acc_addr", 32'(ch_addr), 32'h000020);
    tick();
    chk("rs2_done_wait", 32'(need_wait), 32'h0);
    chk("rs2_done_data", 32'(rdata),     32'h5A5A);
    re = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
